// File: rtl/tec8_datapath_if.sv
// Controller/panel-side signal bundle for the TEC-8 datapath.
// The master drives strobes, ALU controls and switches; the datapath (slave) drives observation outputs.
interface tec8_datapath_if;
    logic       DRW, PCINC, LPC, LAR, PCADD, ARINC, MEMW, LIR, LDZ, LDC;
    logic       ABUS, SBUS, MBUS;
    logic [3:0] S;
    logic       M;
    logic       CIN;
    logic       SELCTL, SEL3, SEL2, SEL1, SEL0;
    logic [7:0] SD;
    logic [3:0] IRH;
    logic       C, Z;
    logic [7:0] PC, AR, IR, BUS;
    logic [15:0] INSCNT;
    logic       BUSERR;

    modport master (
        output DRW, PCINC, LPC, LAR, PCADD, ARINC, MEMW, LIR, LDZ, LDC,
        output ABUS, SBUS, MBUS, S, M, CIN, SELCTL, SEL3, SEL2, SEL1, SEL0, SD,
        input  IRH, C, Z, PC, AR, IR, BUS, INSCNT, BUSERR
    );

    modport slave (
        input  DRW, PCINC, LPC, LAR, PCADD, ARINC, MEMW, LIR, LDZ, LDC,
        input  ABUS, SBUS, MBUS, S, M, CIN, SELCTL, SEL3, SEL2, SEL1, SEL0, SD,
        output IRH, C, Z, PC, AR, IR, BUS, INSCNT, BUSERR
    );
endinterface

// File: rtl/tec8_datapath.sv
// TEC-8 teaching-computer datapath: register file, ALU, PC/AR/IR, flags, 256x8 RAM,
// fetch counter and sticky bus-conflict detector. Single clock T3, synchronous active-low CLR.
module tec8_datapath (
    input  logic             T3,
    input  logic             CLR,
    tec8_datapath_if.slave   dp
);

    // 9-bit ALU result; bit 8 is carry (borrow for subtraction), always 0 for logic ops.
    function automatic logic [8:0] alu_f(
        input logic       m,
        input logic [3:0] s,
        input logic [7:0] a,
        input logic [7:0] b,
        input logic       cin
    );
        logic [8:0] r;
        r = 9'h000;
        if (!m) begin
            case (s)
                4'b1001: r = {1'b0, a} + {1'b0, b} + {8'h00, ~cin};
                4'b0110: r = {1'b0, a} - {1'b0, b} - {8'h00, cin};
                4'b0000: r = {1'b0, a} + {8'h00, ~cin};
                default: r = 9'h000;
            endcase
        end else begin
            case (s)
                4'b1011: r = {1'b0, a & b};
                4'b1110: r = {1'b0, a | b};
                4'b1010: r = {1'b0, b};
                4'b1111: r = {1'b0, a};
                4'b0000: r = {1'b0, ~a};
                default: r = 9'h000;
            endcase
        end
        return r;
    endfunction

    logic [7:0]  r_q [4];
    logic [7:0]  r_d [4];
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  ar_q, ar_d;
    logic [7:0]  ir_q, ir_d;
    logic        c_q, c_d;
    logic        z_q, z_d;
    logic [15:0] inscnt_q, inscnt_d;
    logic        buserr_q, buserr_d;
    logic [7:0]  mem_q [256];

    logic [1:0]  a_idx_s, b_idx_s;
    logic [7:0]  a_s, b_s;
    logic [8:0]  alu_s;
    logic [7:0]  bus_s;
    logic        conflict_s;
    logic        mem_we_s;

    // Operand selection, ALU evaluation and the combinational bus mux.
    always_comb begin
        if (dp.SELCTL) begin
            a_idx_s = {dp.SEL3, dp.SEL2};
            b_idx_s = {dp.SEL1, dp.SEL0};
        end else begin
            a_idx_s = ir_q[3:2];
            b_idx_s = ir_q[1:0];
        end
        a_s   = r_q[a_idx_s];
        b_s   = r_q[b_idx_s];
        alu_s = alu_f(dp.M, dp.S, a_s, b_s, dp.CIN);
        if (dp.MBUS) begin
            bus_s = mem_q[ar_q];
        end else if (dp.SBUS) begin
            bus_s = dp.SD;
        end else if (dp.ABUS) begin
            bus_s = alu_s[7:0];
        end else begin
            bus_s = 8'h00;
        end
        conflict_s = (dp.ABUS & dp.SBUS) | (dp.ABUS & dp.MBUS) | (dp.SBUS & dp.MBUS);
    end

    // Next-state for every register; all terms read pre-edge values only.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            r_d[i] = (dp.DRW && (a_idx_s == 2'(i))) ? bus_s : r_q[i];
        end

        if (dp.LPC) begin
            pc_d = bus_s;
        end else if (dp.PCADD) begin
            pc_d = pc_q + {{4{ir_q[3]}}, ir_q[3:0]};
        end else if (dp.PCINC) begin
            pc_d = pc_q + 8'd1;
        end else begin
            pc_d = pc_q;
        end

        if (dp.LAR) begin
            ar_d = bus_s;
        end else if (dp.ARINC) begin
            ar_d = ar_q + 8'd1;
        end else begin
            ar_d = ar_q;
        end

        if (dp.LIR) begin
            ir_d     = mem_q[pc_q];
            inscnt_d = inscnt_q + 16'd1;
        end else begin
            ir_d     = ir_q;
            inscnt_d = inscnt_q;
        end

        if (dp.LDC) begin
            c_d = alu_s[8];
        end else begin
            c_d = c_q;
        end

        if (dp.LDZ) begin
            z_d = (alu_s[7:0] == 8'h00);
        end else begin
            z_d = z_q;
        end

        buserr_d = buserr_q | conflict_s;
        // Reset suppresses RAM writes along with every other strobe.
        mem_we_s = dp.MEMW & CLR;
    end

    // Architectural registers with synchronous active-low clear.
    always_ff @(posedge T3) begin
        if (!CLR) begin
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= 8'h00;
            end
            pc_q     <= 8'h00;
            ar_q     <= 8'h00;
            ir_q     <= 8'h00;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            inscnt_q <= 16'h0000;
            buserr_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= r_d[i];
            end
            pc_q     <= pc_d;
            ar_q     <= ar_d;
            ir_q     <= ir_d;
            c_q      <= c_d;
            z_q      <= z_d;
            inscnt_q <= inscnt_d;
            buserr_q <= buserr_d;
        end
    end

    // RAM write port; contents survive CLR.
    always_ff @(posedge T3) begin
        if (mem_we_s) begin
            mem_q[ar_q] <= bus_s;
        end
    end

    assign dp.PC     = pc_q;
    assign dp.AR     = ar_q;
    assign dp.IR     = ir_q;
    assign dp.IRH    = ir_q[7:4];
    assign dp.C      = c_q;
    assign dp.Z      = z_q;
    assign dp.INSCNT = inscnt_q;
    assign dp.BUSERR = buserr_q;
    assign dp.BUS    = bus_s;

endmodule

// File: tb/tb_tec8_datapath.sv
// Self-checking bench for tec8_datapath: directed scenarios plus randomized traffic
// compared against a behavioural model of the datapath.
module tb_tec8_datapath;

    logic T3  = 1'b0;
    logic CLR = 1'b1;
    tec8_datapath_if dif();

    tec8_datapath dut (.T3(T3), .CLR(CLR), .dp(dif));

    always #5 T3 = ~T3;

    int total  = 0;
    int passed = 0;

    // Behavioural model state
    logic [7:0] m_r [4];
    logic [7:0] m_pc, m_ar, m_ir;
    bit         m_c, m_z, m_err;
    int         m_cnt;
    logic [7:0] m_mem [256];

    task automatic ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                           input logic m, input logic cin,
                           output logic [7:0] res, output bit co);
        int t;
        res = 8'h00;
        co  = 1'b0;
        if (!m) begin
            if (s == 4'd9) begin
                t = int'(a) + int'(b) + (cin ? 0 : 1);
                res = 8'(t); co = (t > 255);
            end else if (s == 4'd6) begin
                t = int'(a) - int'(b) - (cin ? 1 : 0);
                res = 8'(t); co = (t < 0);
            end else if (s == 4'd0) begin
                t = int'(a) + (cin ? 0 : 1);
                res = 8'(t); co = (t > 255);
            end
        end else begin
            case (s)
                4'd11:   res = a & b;
                4'd14:   res = a | b;
                4'd10:   res = b;
                4'd15:   res = a;
                4'd0:    res = ~a;
                default: res = 8'h00;
            endcase
        end
    endtask

    function automatic int a_sel();
        return dif.SELCTL ? int'({dif.SEL3, dif.SEL2}) : int'(m_ir[3:2]);
    endfunction

    function automatic int b_sel();
        return dif.SELCTL ? int'({dif.SEL1, dif.SEL0}) : int'(m_ir[1:0]);
    endfunction

    task automatic m_bus(output logic [7:0] b, output logic [7:0] res, output bit co);
        ref_alu(m_r[a_sel()], m_r[b_sel()], dif.S, dif.M, dif.CIN, res, co);
        if (dif.MBUS)      b = m_mem[m_ar];
        else if (dif.SBUS) b = dif.SD;
        else if (dif.ABUS) b = res;
        else               b = 8'h00;
    endtask

    task automatic model_step();
        logic [7:0] b, res, pc0, ar0, ir0;
        bit co;
        int ai, off;
        m_bus(b, res, co);
        ai = a_sel();
        pc0 = m_pc; ar0 = m_ar; ir0 = m_ir;
        if (!CLR) begin
            for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
            m_pc = 8'h00; m_ar = 8'h00; m_ir = 8'h00;
            m_c = 1'b0; m_z = 1'b0; m_cnt = 0; m_err = 1'b0;
        end else begin
            if (int'(dif.ABUS) + int'(dif.SBUS) + int'(dif.MBUS) >= 2) m_err = 1'b1;
            if (dif.LIR) begin
                m_ir  = m_mem[pc0];
                m_cnt = (m_cnt + 1) % 65536;
            end
            if (dif.MEMW) m_mem[ar0] = b;
            if (dif.DRW) m_r[ai] = b;
            if (dif.LPC) m_pc = b;
            else if (dif.PCADD) begin
                off  = ir0[3] ? int'(ir0[3:0]) - 16 : int'(ir0[3:0]);
                m_pc = 8'(int'(pc0) + off);
            end else if (dif.PCINC) m_pc = 8'(int'(pc0) + 1);
            if (dif.LAR) m_ar = b;
            else if (dif.ARINC) m_ar = 8'(int'(ar0) + 1);
            if (dif.LDC) m_c = co;
            if (dif.LDZ) m_z = (res == 8'h00);
        end
    endtask

    task automatic idle();
        {dif.DRW, dif.PCINC, dif.LPC, dif.LAR, dif.PCADD, dif.ARINC, dif.MEMW, dif.LIR, dif.LDZ, dif.LDC} = 10'd0;
        {dif.ABUS, dif.SBUS, dif.MBUS} = 3'd0;
        dif.S = 4'd0; dif.M = 1'b0; dif.CIN = 1'b1;
        {dif.SELCTL, dif.SEL3, dif.SEL2, dif.SEL1, dif.SEL0} = 5'd0;
        dif.SD = 8'h00;
        CLR = 1'b1;
    endtask

    task automatic cycle();
        model_step();
        @(posedge T3);
        #1;
    endtask

    // Present register i on BUS through the ALU's pass-A function (no clock edge).
    task automatic show_reg(input int i);
        idle();
        dif.SELCTL = 1'b1; {dif.SEL3, dif.SEL2} = 2'(i);
        dif.M = 1'b1; dif.S = 4'b1111; dif.ABUS = 1'b1;
        #1;
    endtask

    task automatic sbus_load(input logic [7:0] v, input bit lar, input bit lpc, input bit memw);
        idle();
        dif.SBUS = 1'b1; dif.SD = v; dif.LAR = lar; dif.LPC = lpc; dif.MEMW = memw;
        cycle();
    endtask

    task automatic panel_write(input int i, input logic [7:0] v);
        idle();
        dif.SELCTL = 1'b1; {dif.SEL3, dif.SEL2} = 2'(i);
        dif.SBUS = 1'b1; dif.DRW = 1'b1; dif.SD = v;
        cycle();
    endtask

    task automatic test_reset();
        idle();
        CLR = 1'b0; dif.PCINC = 1'b1; dif.DRW = 1'b1;
        cycle();
        idle();
        total++; if (dif.PC !== 8'h00) $display("FAIL reset_pc: got %h want 00", dif.PC); else passed++;
        total++; if (dif.AR !== 8'h00) $display("FAIL reset_ar: got %h want 00", dif.AR); else passed++;
        total++; if (dif.IR !== 8'h00) $display("FAIL reset_ir: got %h want 00", dif.IR); else passed++;
        total++; if ({dif.C, dif.Z} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {dif.C, dif.Z}); else passed++;
        total++; if (dif.INSCNT !== 16'h0000) $display("FAIL reset_inscnt: got %h want 0000", dif.INSCNT); else passed++;
        total++; if (dif.BUSERR !== 1'b0) $display("FAIL reset_buserr: got %b want 0", dif.BUSERR); else passed++;
        for (int i = 0; i < 4; i++) begin
            show_reg(i);
            total++; if (dif.BUS !== 8'h00) $display("FAIL reset_r%0d: got %h want 00", i, dif.BUS); else passed++;
        end
    endtask

    task automatic init_ram();
        sbus_load(8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            idle();
            dif.SBUS = 1'b1; dif.SD = 8'($urandom); dif.MEMW = 1'b1; dif.ARINC = 1'b1;
            cycle();
        end
    endtask

    task automatic test_panel_write();
        idle();
        dif.SELCTL = 1'b1; {dif.SEL3, dif.SEL2} = 2'b01;
        dif.SBUS = 1'b1; dif.DRW = 1'b1; dif.SD = 8'h5A;
        #1;
        total++; if (dif.BUS !== 8'h5A) $display("FAIL panel_bus: got %h want 5a", dif.BUS); else passed++;
        cycle();
        show_reg(1);
        total++; if (dif.BUS !== 8'h5A) $display("FAIL panel_r1: got %h want 5a", dif.BUS); else passed++;
    endtask

    task automatic test_add();
        panel_write(0, 8'hFF);
        panel_write(1, 8'h01);
        sbus_load(8'h00, 1'b1, 1'b1, 1'b0);
        sbus_load(8'h11, 1'b0, 1'b0, 1'b1);
        idle(); dif.LIR = 1'b1; cycle();
        total++; if (dif.IR !== 8'h11) $display("FAIL add_ir: got %h want 11", dif.IR); else passed++;
        idle();
        dif.M = 1'b0; dif.S = 4'b1001; dif.CIN = 1'b1;
        dif.ABUS = 1'b1; dif.DRW = 1'b1; dif.LDC = 1'b1; dif.LDZ = 1'b1;
        #1;
        total++; if (dif.BUS !== 8'h00) $display("FAIL add_bus: got %h want 00", dif.BUS); else passed++;
        cycle();
        total++; if (dif.C !== 1'b1) $display("FAIL add_c: got %b want 1", dif.C); else passed++;
        total++; if (dif.Z !== 1'b1) $display("FAIL add_z: got %b want 1", dif.Z); else passed++;
        show_reg(0);
        total++; if (dif.BUS !== 8'h00) $display("FAIL add_r0: got %h want 00", dif.BUS); else passed++;
    endtask

    task automatic test_fetch();
        idle(); CLR = 1'b0; cycle();
        sbus_load(8'h00, 1'b1, 1'b0, 1'b0);
        sbus_load(8'h95, 1'b0, 1'b0, 1'b1);
        idle(); dif.LIR = 1'b1; dif.PCINC = 1'b1; cycle();
        total++; if (dif.IR !== 8'h95) $display("FAIL fetch_ir: got %h want 95", dif.IR); else passed++;
        total++; if (dif.IRH !== 4'h9) $display("FAIL fetch_irh: got %h want 9", dif.IRH); else passed++;
        total++; if (dif.PC !== 8'h01) $display("FAIL fetch_pc: got %h want 01", dif.PC); else passed++;
        total++; if (dif.INSCNT !== 16'h0001) $display("FAIL fetch_inscnt: got %h want 0001", dif.INSCNT); else passed++;
    endtask

    task automatic test_inscnt_wrap();
        idle(); dif.LIR = 1'b1;
        while (m_cnt != 65535) cycle();
        total++; if (dif.INSCNT !== 16'hFFFF) $display("FAIL inscnt_max: got %h want ffff", dif.INSCNT); else passed++;
        cycle();
        total++; if (dif.INSCNT !== 16'h0000) $display("FAIL inscnt_wrap: got %h want 0000", dif.INSCNT); else passed++;
    endtask

    task automatic test_branch();
        sbus_load(8'h20, 1'b1, 1'b1, 1'b0);
        sbus_load(8'h7E, 1'b0, 1'b0, 1'b1);
        idle(); dif.LIR = 1'b1; cycle();
        sbus_load(8'h10, 1'b0, 1'b1, 1'b0);
        idle(); dif.PCADD = 1'b1; dif.PCINC = 1'b1; cycle();
        total++; if (dif.PC !== 8'h0E) $display("FAIL branch_pcadd: got %h want 0e", dif.PC); else passed++;
        sbus_load(8'h40, 1'b0, 1'b1, 1'b0);
        total++; if (dif.PC !== 8'h40) $display("FAIL branch_lpc: got %h want 40", dif.PC); else passed++;
    endtask

    task automatic test_bus_conflict();
        idle(); CLR = 1'b0; cycle();
        idle(); dif.SBUS = 1'b1; dif.ABUS = 1'b1; dif.SD = 8'h33;
        #1;
        total++; if (dif.BUS !== 8'h33) $display("FAIL conflict_bus: got %h want 33", dif.BUS); else passed++;
        cycle();
        total++; if (dif.BUSERR !== 1'b1) $display("FAIL conflict_set: got %b want 1", dif.BUSERR); else passed++;
        idle(); cycle(); cycle();
        total++; if (dif.BUSERR !== 1'b1) $display("FAIL conflict_sticky: got %b want 1", dif.BUSERR); else passed++;
        idle(); CLR = 1'b0; cycle();
        total++; if (dif.BUSERR !== 1'b0) $display("FAIL conflict_clear: got %b want 0", dif.BUSERR); else passed++;
    endtask

    task automatic test_random();
        logic [3:0] codes [7] = '{4'd9, 4'd6, 4'd0, 4'd11, 4'd14, 4'd10, 4'd15};
        logic [7:0] eb, er;
        bit ec;
        for (int n = 0; n < 400; n++) begin
            idle();
            {dif.DRW, dif.PCINC, dif.LPC, dif.LAR, dif.PCADD, dif.ARINC, dif.MEMW, dif.LIR, dif.LDZ, dif.LDC} = 10'($urandom);
            dif.ABUS = ($urandom_range(0, 2) == 0);
            dif.SBUS = ($urandom_range(0, 2) == 0);
            dif.MBUS = ($urandom_range(0, 3) == 0);
            dif.M    = 1'($urandom);
            dif.S    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : codes[$urandom_range(0, 6)];
            dif.CIN  = 1'($urandom);
            {dif.SELCTL, dif.SEL3, dif.SEL2, dif.SEL1, dif.SEL0} = 5'($urandom);
            dif.SD   = 8'($urandom);
            CLR      = ($urandom_range(0, 39) != 0);
            #1;
            m_bus(eb, er, ec);
            total++; if (dif.BUS !== eb) $display("FAIL rnd_bus[%0d]: got %h want %h", n, dif.BUS, eb); else passed++;
            cycle();
            total++; if (dif.PC !== m_pc) $display("FAIL rnd_pc[%0d]: got %h want %h", n, dif.PC, m_pc); else passed++;
            total++; if (dif.AR !== m_ar) $display("FAIL rnd_ar[%0d]: got %h want %h", n, dif.AR, m_ar); else passed++;
            total++; if (dif.IR !== m_ir || dif.IRH !== m_ir[7:4]) $display("FAIL rnd_ir[%0d]: got %h/%h want %h", n, dif.IR, dif.IRH, m_ir); else passed++;
            total++; if ({dif.C, dif.Z} !== {m_c, m_z}) $display("FAIL rnd_flags[%0d]: got %b want %b", n, {dif.C, dif.Z}, {m_c, m_z}); else passed++;
            total++; if (dif.INSCNT !== 16'(m_cnt)) $display("FAIL rnd_inscnt[%0d]: got %h want %h", n, dif.INSCNT, 16'(m_cnt)); else passed++;
            total++; if (dif.BUSERR !== m_err) $display("FAIL rnd_buserr[%0d]: got %b want %b", n, dif.BUSERR, m_err); else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            show_reg(i);
            total++; if (dif.BUS !== m_r[i]) $display("FAIL rnd_r%0d: got %h want %h", i, dif.BUS, m_r[i]); else passed++;
        end
    endtask

    initial begin
        idle();
        #1;
        test_reset();
        init_ram();
        test_panel_write();
        test_add();
        test_fetch();
        test_inscnt_wrap();
        test_branch();
        test_bus_conflict();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tec8_datapath.md
TEC8_DATAPATH -- requirements
Module: tec8_datapath

Interface
REQ-001 SHALL have port: T3  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: CLR  input  1  reset; synchronous, active-low, sampled on rising T3.
REQ-003 SHALL have ports: DRW, PCINC, LPC, LAR, PCADD, ARINC, MEMW, LIR, LDZ, LDC  input  1 each  register/memory load strobes from controller.
REQ-004 SHALL have ports: ABUS, SBUS, MBUS  input  1 each  bus-source enables (ALU, switches, memory).
REQ-005 SHALL have ports: S  input  4  ALU function; M  input  1  1=logic, 0=arithmetic; CIN  input  1  carry-in, active-low.
REQ-006 SHALL have ports: SELCTL  input  1  panel register select; SEL3..SEL0  input  1 each  panel register selects.
REQ-007 SHALL have port: SD  input  8  panel switch data.
REQ-008 SHALL have ports: IRH  output  4  IR[7:4]; C  output  1  carry flag; Z  output  1  zero flag.
REQ-009 SHALL have ports: PC, AR, IR, BUS  output  8 each  register and bus observation.
REQ-010 SHALL have ports: INSCNT  output  16  fetch counter; BUSERR  output  1  sticky bus-conflict flag.

Function
REQ-011 Storage SHALL be: R0-R3 (8b), PC, AR, IR (8b), C, Z, 256x8 RAM, INSCNT, BUSERR.
REQ-012 Operand select SHALL be: SELCTL=0 -> A=R[IR[3:2]], B=R[IR[1:0]]; SELCTL=1 -> A=R[{SEL3,SEL2}], B=R[{SEL1,SEL0}].
REQ-013 ALU arithmetic (M=0) SHALL be 9-bit: S=1001 A+B+~CIN; S=0110 A-B-CIN; S=0000 A+~CIN; carry-out = bit 8 (borrow for 0110).
REQ-014 ALU logic (M=1) SHALL be: 1011 A&B; 1110 A|B; 1010 B; 1111 A; 0000 ~A; carry-out 0.
REQ-015 Any other {M,S} code SHALL give result 00, carry-out 0.
REQ-016 BUS SHALL be combinational: MBUS -> RAM[AR]; else SBUS -> SD; else ABUS -> ALU result; else 00.
REQ-017 BUSERR SHALL set on any edge where two or more of ABUS/SBUS/MBUS are 1; cleared only by reset.
REQ-018 DRW SHALL write BUS into the register addressed as A.
REQ-019 PC update priority SHALL be: LPC -> BUS; else PCADD -> PC + sign-extended IR[3:0]; else PCINC -> PC+1; mod 256.
REQ-020 AR update priority SHALL be: LAR -> BUS; else ARINC -> AR+1; mod 256.
REQ-021 LIR SHALL load IR <= RAM[PC] using pre-edge PC and increment INSCNT (FFFF wraps to 0000).
REQ-022 MEMW SHALL write BUS into RAM[AR] using pre-edge AR.
REQ-023 LDC SHALL load C <= ALU carry-out; LDZ SHALL load Z <= (ALU result == 00); flags are otherwise held.
REQ-024 Simultaneous strobes SHALL all use pre-edge values.
REQ-025 A register SHALL hold its value when no strobe targets it.
REQ-026 IRH SHALL track IR[7:4] continuously.

Reset
REQ-027 CLR=0 at a rising T3 SHALL zero R0-R3, PC, AR, IR, C, Z, INSCNT, BUSERR; RAM contents SHALL be kept.
REQ-028 Reset SHALL override all strobes in the same cycle, including mid-instruction.
REQ-029 While CLR=0, BUS SHALL remain combinational per REQ-016.

Verification
REQ-030 Reset: CLR=0 for one edge with PCINC=1 and DRW=1 -> all REQ-027 state = 0, BUSERR=0.
REQ-031 Panel write: SELCTL=1, {SEL3,SEL2}=01, SBUS=1, DRW=1, SD=5A -> R1=5A and BUS=5A.
REQ-032 ADD: R0=FF, R1=01, IR=11, M=0, S=1001, CIN=1, ABUS=DRW=LDC=LDZ=1 -> R0=00, C=1, Z=1.
REQ-033 Fetch: RAM[00]=95, PC=00, LIR=PCINC=1 -> IR=95, IRH=9, PC=01, INSCNT=0001; INSCNT=FFFF plus one more LIR -> 0000.
REQ-034 Branch: IR=7E, PC=10, PCADD=1 with PCINC=1 -> PC=0E; then LPC=1 with SBUS=1, SD=40 -> PC=40.
REQ-035 Bus conflict: SBUS=ABUS=1, SD=33 -> BUS=33, BUSERR=1; BUSERR stays 1 after sources drop and clears only on CLR=0.
